act_unit_pipe: RTL

Streaming, parametrised fixed-point activation unit for the convolution output path. It accepts one signed sample per cycle on a valid/ready handshake and applies a per-sample-selected activation: bypass, ReLU, sigmoid or SiLU. Sigmoid uses a shift-only piecewise-linear approximation; SiLU multiplies the input by that result. It sits between the accumulator/requantiser and the feature-map writer, and flags the last sample of each frame.

---
 rtl/act_unit_pipe.sv | 86 ++++++++
 1 files changed

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: 3-stage streaming fixed-point activation (bypass, ReLU, sigmoid, SiLU) with a frame-last flag
// Ports: clk; reset (synchronous, active-low);
//   in_valid/in_ready/in_data/in_mode: input stream, mode 00 bypass, 01 ReLU, 10 sigmoid, 11 SiLU;
//   out_valid/out_ready/out_data/out_last: output stream, out_last marks the final sample of each FRAME_LEN frame.
// Build option: ACT_LEAKY_EN turns mode 01 into leaky ReLU (x<0 -> x>>>3).
module act_unit_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int CNT_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);
  localparam logic [DATA_W-1:0] HALF = DATA_W'(1 << (FRAC_W - 1));
  localparam logic [DATA_W-1:0] T5 = DATA_W'(5 << FRAC_W);
  localparam logic [DATA_W-1:0] T2 = DATA_W'(19 << (FRAC_W - 3));
  localparam logic [DATA_W-1:0] C2 = DATA_W'(27 << (FRAC_W - 5));
  localparam logic [DATA_W-1:0] C1 = DATA_W'(5 << (FRAC_W - 3));
  localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [2*DATA_W-1:0] SMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [2*DATA_W-1:0] RND = {{(2*DATA_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  logic en;
  logic [DATA_W-1:0] abs_x, y, sig, relu, res, silu;
  logic [1:0] seg;
  logic v1, n1, v2;
  logic [DATA_W-1:0] x1, a1, x2, sg2;
  logic [1:0] m1, g1, m2;
  logic signed [2*DATA_W-1:0] xw, sw, prod, rnd;
  logic [CNT_W-1:0] cnt;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  // most negative input has no positive twin, so it saturates to max positive
  assign abs_x = !in_data[DATA_W-1] ? in_data : in_data == MINN ? MAXP : -in_data;
  assign seg = abs_x >= T5 ? 2'd3 : abs_x >= T2 ? 2'd2 : abs_x >= ONE ? 2'd1 : 2'd0;
  assign y = g1 == 2'd3 ? ONE : g1 == 2'd2 ? (a1 >> 5) + C2 : g1 == 2'd1 ? (a1 >> 3) + C1 : (a1 >> 2) + HALF;
  assign sig = n1 ? ONE - y : y;
  assign xw = {{DATA_W{x2[DATA_W-1]}}, x2};
  assign sw = {{DATA_W{1'b0}}, sg2};
  assign prod = xw * sw;
  assign rnd = (prod + RND) >>> FRAC_W;
  assign silu = rnd > SMAX ? MAXP : rnd < SMIN ? MINN : rnd[DATA_W-1:0];
`ifdef ACT_LEAKY_EN
  assign relu = x2[DATA_W-1] ? {{3{1'b1}}, x2[DATA_W-1:3]} : x2;
`else
  assign relu = x2[DATA_W-1] ? '0 : x2;
`endif
  assign res = m2 == 2'd0 ? x2 : m2 == 2'd1 ? relu : m2 == 2'd2 ? sg2 : silu;
  assign out_last = out_valid && cnt == LAST;
  always_ff @(posedge clk)
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      cnt <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        x1 <= in_data;
        m1 <= in_mode;
        a1 <= abs_x;
        n1 <= in_data[DATA_W-1];
        g1 <= seg;
        v2 <= v1;
        x2 <= x1;
        m2 <= m1;
        sg2 <= sig;
        out_valid <= v2;
        out_data <= res;
      end
      if (out_valid && out_ready) cnt <= cnt == LAST ? '0 : cnt + CNT_W'(1);
    end
endmodule
